// File: rtl/srl_fifo_ctrl.sv
// srl_fifo_ctrl
//   Turns an external bank of SRL32-style shift registers into a
//   first-word-fall-through FIFO. The bank has one primitive per data bit,
//   with a shared CE and a shared address. New words shift in at address 0,
//   so the oldest stored word always sits at address cnt-1. The head word
//   is held in an output register, which gives a total capacity of DEPTH+1.
//
// Ports
//   CLK, RST_N           clock; asynchronous active-low reset
//   FLUSH                synchronous clear of all occupancy
//   S_VALID/S_READY      producer handshake, data on S_DATA
//   SRL_CE/SRL_D/SRL_A   shift enable, shift data and read address to the bank
//   SRL_Q                combinational read data from the bank (data[SRL_A])
//   M_VALID/M_READY      consumer handshake, head word on M_DATA
//   COUNT                total occupancy (SRL words + output register)
//   AFULL                registered, COUNT >= AFULL_THR
module srl_fifo_ctrl #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 32,
    parameter int ADDR_W    = 5,
    parameter int AFULL_THR = 28
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              FLUSH,
    input  logic              S_VALID,
    output logic              S_READY,
    input  logic [DATA_W-1:0] S_DATA,
    output logic              SRL_CE,
    output logic [DATA_W-1:0] SRL_D,
    output logic [ADDR_W-1:0] SRL_A,
    input  logic [DATA_W-1:0] SRL_Q,
    output logic              M_VALID,
    input  logic              M_READY,
    output logic [DATA_W-1:0] M_DATA,
    output logic [ADDR_W:0]   COUNT,
    output logic              AFULL
);

    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] THR_C   = CW'(AFULL_THR);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FILL,
        ST_FULL
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [CW-1:0] count_next;
    logic          rdy_en;
    logic          wr;
    logic          ld;
    logic          m_valid_next;

    function automatic state_t state_of(input logic [CW-1:0] c);
        if (c == '0)
            return ST_EMPTY;
        else if (c == DEPTH_C)
            return ST_FULL;
        else
            return ST_FILL;
    endfunction

    always_comb begin
        S_READY = rdy_en & (state != ST_FULL) & ~FLUSH;
        wr      = S_VALID & S_READY;
        // The head register reloads whenever it is empty or being consumed.
        ld      = (cnt != '0) & (~M_VALID | M_READY) & ~FLUSH;

        if (FLUSH)
            cnt_next = '0;
        else if (wr && !ld)
            cnt_next = cnt + ONE_C;
        else if (!wr && ld)
            cnt_next = cnt - ONE_C;
        else
            cnt_next = cnt;

        if (FLUSH)
            m_valid_next = 1'b0;
        else if (ld)
            m_valid_next = 1'b1;
        else if (M_VALID && M_READY)
            m_valid_next = 1'b0;
        else
            m_valid_next = M_VALID;

        count_next = cnt_next + {{ADDR_W{1'b0}}, m_valid_next};
        state_next = state_of(cnt_next);
    end

    assign SRL_CE = wr;
    assign SRL_D  = S_DATA;
    // The oldest word is at cnt-1. SRL_Q is read before this edge's shift.
    assign SRL_A  = (cnt != '0) ? ADDR_W'(cnt - ONE_C) : '0;
    assign COUNT  = cnt + {{ADDR_W{1'b0}}, M_VALID};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rdy_en  <= 1'b0;
            cnt     <= '0;
            state   <= ST_EMPTY;
            M_VALID <= 1'b0;
            M_DATA  <= '0;
            AFULL   <= 1'b0;
        end else begin
            rdy_en  <= 1'b1;
            cnt     <= cnt_next;
            state   <= state_next;
            M_VALID <= m_valid_next;
            if (ld)
                M_DATA <= SRL_Q;
            // AFULL is registered from the next COUNT, so both change on the same edge.
            AFULL   <= (count_next >= THR_C);
        end
    end

endmodule

// File: tb/tb_srl_fifo_ctrl.sv
module tb_srl_fifo_ctrl;

    localparam int DATA_W    = 8;
    localparam int DEPTH     = 32;
    localparam int ADDR_W    = 5;
    localparam int AFULL_THR = 28;

    logic              CLK;
    logic              RST_N;
    logic              FLUSH;
    logic              S_VALID;
    logic              S_READY;
    logic [DATA_W-1:0] S_DATA;
    logic              SRL_CE;
    logic [DATA_W-1:0] SRL_D;
    logic [ADDR_W-1:0] SRL_A;
    logic [DATA_W-1:0] SRL_Q;
    logic              M_VALID;
    logic              M_READY;
    logic [DATA_W-1:0] M_DATA;
    logic [ADDR_W:0]   COUNT;
    logic              AFULL;

    srl_fifo_ctrl #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .AFULL_THR(AFULL_THR)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH),
        .S_VALID(S_VALID), .S_READY(S_READY), .S_DATA(S_DATA),
        .SRL_CE(SRL_CE), .SRL_D(SRL_D), .SRL_A(SRL_A), .SRL_Q(SRL_Q),
        .M_VALID(M_VALID), .M_READY(M_READY), .M_DATA(M_DATA),
        .COUNT(COUNT), .AFULL(AFULL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural SRL bank: shift in at address 0 and read asynchronously.
    logic [DATA_W-1:0] srl_mem [0:(1<<ADDR_W)-1];
    initial for (int i = 0; i < (1<<ADDR_W); i++) srl_mem[i] = '0;
    always @(posedge CLK) begin
        if (SRL_CE) begin
            for (int i = (1<<ADDR_W)-1; i > 0; i--) srl_mem[i] <= srl_mem[i-1];
            srl_mem[0] <= SRL_D;
        end
    end
    assign SRL_Q = srl_mem[SRL_A];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model. The SRL words are kept in a queue (oldest first),
    // and the output register is modelled separately.
    logic [DATA_W-1:0] q[$];
    bit                m_mv, m_rdy, m_af;
    logic [DATA_W-1:0] m_md;
    bit                e_wr, e_ld, cur_rn, cur_fl, cur_mr;
    logic [DATA_W-1:0] cur_d;

    function automatic int model_total();
        return q.size() + int'(m_mv);
    endfunction

    task automatic model_reset();
        q.delete();
        m_mv  = 0;
        m_rdy = 0;
        m_af  = 0;
        m_md  = '0;
    endtask

    task automatic drive_check(input logic rn, input logic fl, input logic sv,
                               input logic [DATA_W-1:0] d, input logic mr);
        bit e_rdy;
        int e_a;
        RST_N   = rn;
        FLUSH   = fl;
        S_VALID = sv;
        S_DATA  = d;
        M_READY = mr;
        if (!rn) model_reset();
        @(negedge CLK);
        e_rdy  = rn && m_rdy && (q.size() < DEPTH) && !fl;
        e_ld   = rn && (q.size() > 0) && (!m_mv || mr) && !fl;
        e_wr   = sv && e_rdy;
        e_a    = (q.size() > 0) ? q.size() - 1 : 0;
        cur_rn = rn;
        cur_fl = fl;
        cur_mr = mr;
        cur_d  = d;
        chk("s_ready", 32'(S_READY), 32'(e_rdy));
        chk("srl_ce",  32'(SRL_CE),  32'(e_wr));
        chk("srl_d",   32'(SRL_D),   32'(d));
        chk("srl_a",   32'(SRL_A),   32'(e_a));
        chk("m_valid", 32'(M_VALID), 32'(m_mv));
        chk("m_data",  32'(M_DATA),  32'(m_md));
        chk("count",   32'(COUNT),   32'(model_total()));
        chk("afull",   32'(AFULL),   32'(m_af));
    endtask

    task automatic advance();
        @(posedge CLK);
        if (cur_rn) begin
            if (cur_fl) begin
                q.delete();
                m_mv = 0;
            end else begin
                if (e_ld) begin
                    m_md = q.pop_front();
                    m_mv = 1;
                end else if (m_mv && cur_mr) begin
                    m_mv = 0;
                end
                if (e_wr) q.push_back(cur_d);
            end
            m_rdy = 1;
            m_af  = (model_total() >= AFULL_THR);
        end
        #1;
    endtask

    task automatic step(input logic rn, input logic fl, input logic sv,
                        input logic [DATA_W-1:0] d, input logic mr);
        drive_check(rn, fl, sv, d, mr);
        advance();
    endtask

    task automatic empty_out();
        step(1, 1, 0, '0, 0);
        step(1, 0, 0, '0, 0);
    endtask

    // Consume n words with M_READY held high; they must start at 'first' and increment.
    task automatic drain(input logic [DATA_W-1:0] first, input int n, input string nm);
        logic [DATA_W-1:0] exp_d;
        int got;
        exp_d = first;
        got   = 0;
        for (int c = 0; c < n + 6 && got < n; c++) begin
            drive_check(1, 0, 0, '0, 1);
            if (M_VALID) begin
                chk(nm, 32'(M_DATA), 32'(exp_d));
                exp_d++;
                got++;
            end
            advance();
        end
        chk({nm, "_cnt"}, 32'(got), 32'(n));
    endtask

    typedef struct {
        logic              fl, sv, mr;
        logic [DATA_W-1:0] d;
        logic              e_rdy, e_ce, e_mv;
        logic [DATA_W-1:0] e_md;
        int                e_cnt;
    } vec_t;

    vec_t vt[8];

    initial begin
        int w;
        int cyc;
        logic [DATA_W-1:0] sd;

        vt[0] = '{fl:0, sv:1, mr:0, d:8'hA5, e_rdy:1, e_ce:1, e_mv:0, e_md:8'h00, e_cnt:0};
        vt[1] = '{fl:0, sv:0, mr:0, d:8'h00, e_rdy:1, e_ce:0, e_mv:0, e_md:8'h00, e_cnt:1};
        vt[2] = '{fl:0, sv:0, mr:0, d:8'h00, e_rdy:1, e_ce:0, e_mv:1, e_md:8'hA5, e_cnt:1};
        vt[3] = '{fl:0, sv:0, mr:1, d:8'h00, e_rdy:1, e_ce:0, e_mv:1, e_md:8'hA5, e_cnt:1};
        vt[4] = '{fl:0, sv:0, mr:0, d:8'h00, e_rdy:1, e_ce:0, e_mv:0, e_md:8'hA5, e_cnt:0};
        vt[5] = '{fl:0, sv:1, mr:0, d:8'h3C, e_rdy:1, e_ce:1, e_mv:0, e_md:8'hA5, e_cnt:0};
        vt[6] = '{fl:1, sv:1, mr:0, d:8'hC3, e_rdy:0, e_ce:0, e_mv:0, e_md:8'hA5, e_cnt:1};
        vt[7] = '{fl:0, sv:0, mr:0, d:8'h00, e_rdy:1, e_ce:0, e_mv:0, e_md:8'hA5, e_cnt:0};

        RST_N = 0; FLUSH = 0; S_VALID = 0; S_DATA = '0; M_READY = 0;
        model_reset();

        // Reset release: S_READY stays low during reset and for the first cycle after it.
        for (int i = 0; i < 3; i++) step(0, 0, 1, 8'h11, 0);
        drive_check(1, 0, 1, 8'h11, 0);
        chk("rst_rel_s_ready", 32'(S_READY), 32'(0));
        advance();
        drive_check(1, 0, 0, '0, 0);
        chk("post_rst_s_ready", 32'(S_READY), 32'(1));
        advance();

        // Single word, then a flush that holds M_DATA.
        for (int i = 0; i < 8; i++) begin
            drive_check(1, vt[i].fl, vt[i].sv, vt[i].d, vt[i].mr);
            chk($sformatf("tv%0d_s_ready", i), 32'(S_READY), 32'(vt[i].e_rdy));
            chk($sformatf("tv%0d_srl_ce", i),  32'(SRL_CE),  32'(vt[i].e_ce));
            chk($sformatf("tv%0d_m_valid", i), 32'(M_VALID), 32'(vt[i].e_mv));
            chk($sformatf("tv%0d_m_data", i),  32'(M_DATA),  32'(vt[i].e_md));
            chk($sformatf("tv%0d_count", i),   32'(COUNT),   32'(vt[i].e_cnt));
            advance();
        end

        // Fill to full with 0x00..0x20, then drain in order.
        empty_out();
        w = 0;
        for (cyc = 0; cyc < 60 && w < 33; cyc++) begin
            drive_check(1, 0, 1, DATA_W'(w), 0);
            if (e_wr) w++;
            advance();
        end
        chk("fill_accepts", 32'(w), 32'(33));
        drive_check(1, 0, 1, 8'hEE, 0);
        chk("full_s_ready", 32'(S_READY), 32'(0));
        chk("full_count", 32'(COUNT), 32'(33));
        chk("full_afull", 32'(AFULL), 32'(1));
        advance();
        drain(8'h00, 33, "fill_drain");

        // Streaming: after a two-cycle fill, one word per cycle and COUNT steady at 2.
        empty_out();
        for (int k = 0; k < 100; k++) begin
            drive_check(1, 0, 1, DATA_W'(k), 1);
            if (k >= 2) begin
                chk("stream_m_valid", 32'(M_VALID), 32'(1));
                chk("stream_m_data", 32'(M_DATA), 32'(DATA_W'(k - 2)));
                chk("stream_count", 32'(COUNT), 32'(2));
            end
            advance();
        end

        // Simultaneous write and load with 31 words in the SRL.
        empty_out();
        w = 0;
        for (cyc = 0; cyc < 60 && model_total() < 32; cyc++) begin
            drive_check(1, 0, 1, DATA_W'(8'h40 + w), 0);
            if (e_wr) w++;
            advance();
        end
        chk("fm1_total", 32'(COUNT), 32'(32));
        drive_check(1, 0, 1, DATA_W'(8'h40 + w), 1);
        chk("fm1_srl_a", 32'(SRL_A), 32'(30));
        chk("fm1_srl_ce", 32'(SRL_CE), 32'(1));
        chk("fm1_head", 32'(M_DATA), 32'(8'h40));
        advance();
        drive_check(1, 0, 0, '0, 0);
        chk("fm1_count_after", 32'(COUNT), 32'(32));
        chk("fm1_srl_a_after", 32'(SRL_A), 32'(30));
        advance();
        drain(8'h41, 32, "fm1_drain");

        // Flush with COUNT=10 and S_VALID high.
        empty_out();
        for (cyc = 0; cyc < 40 && model_total() < 10; cyc++) step(1, 0, 1, DATA_W'(cyc), 0);
        chk("flush_pre_count", 32'(COUNT), 32'(10));
        drive_check(1, 1, 1, 8'h77, 0);
        chk("flush_s_ready", 32'(S_READY), 32'(0));
        advance();
        drive_check(1, 0, 0, '0, 0);
        chk("flush_m_valid", 32'(M_VALID), 32'(0));
        chk("flush_count", 32'(COUNT), 32'(0));
        advance();
        step(1, 0, 1, 8'h5A, 0);
        for (cyc = 0; cyc < 5 && !M_VALID; cyc++) step(1, 0, 0, '0, 0);
        chk("flush_next_valid", 32'(M_VALID), 32'(1));
        chk("flush_next_data", 32'(M_DATA), 32'(8'h5A));

        // Randomized traffic with occasional flush and reset.
        for (int k = 0; k < 3000; k++) begin
            logic rn, fl, sv, mr;
            int ph;
            ph = (k / 300) % 3;
            rn = ($urandom_range(0, 399) != 0);
            fl = ($urandom_range(0, 49) == 0);
            sv = (ph == 1) ? ($urandom_range(0, 9) < 9) : ($urandom_range(0, 9) < 6);
            mr = (ph == 1) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 6);
            sd = DATA_W'($urandom);
            step(rn, fl, sv, sd, mr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
